sd_cmd_sequencer: RTL and testbench

SD_CMD_SEQUENCER -- requirements
Module: sd_cmd_sequencer

---
 rtl/sd_cmd_sequencer.sv | 253 +++++++++++++++++++++++++
 tb/tb_sd_cmd_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_sequencer.sv
// sd_cmd_sequencer: SD SPI-mode command framer and R1 response poller.
// Presents the 6-byte command frame to an external SPI byte engine, then
// sends 0xFF poll bytes until an R1 byte (bit 7 clear) arrives or
// POLL_LIMIT polls have gone unanswered.
// Optional build macro SD_CMD_CRC_GEN_EN: when defined, the CRC7 in byte 6
// is generated internally from the latched index/argument and cmd_crc is
// ignored. When undefined, cmd_crc is used as supplied.
module sd_cmd_sequencer #(
  parameter int POLL_LIMIT = 8
) (
  input  logic        MasterCLK,
  input  logic        Reset,
  input  logic        cmd_start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic [6:0]  cmd_crc,
  output logic        busy,
  output logic        done,
  output logic [7:0]  resp,
  output logic        timeout,
  output logic [7:0]  OuputDataRegister,
  output logic        SPI_EnableRegister,
  input  logic [7:0]  InputDataRegister,
  input  logic        DataClockRegister
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEND   = 2'd1;
  localparam logic [1:0] POLL   = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  // Index of the last frame byte and of the last permitted poll.
  localparam logic [2:0] LAST_BYTE = 3'd5;
  localparam logic [7:0] POLL_LAST = 8'(POLL_LIMIT - 1);

  // Registered state
  logic [1:0]  r_state;
  logic [2:0]  r_byte_cnt;
  logic [7:0]  r_poll_cnt;
  logic [5:0]  r_index;
  logic [31:0] r_arg;
  logic [6:0]  r_crc;
  logic        r_dclk_prev;
  logic [7:0]  r_out;
  logic        r_en;
  logic        r_busy;
  logic        r_done;
  logic [7:0]  r_resp;
  logic        r_timeout;

  // Next-state values
  logic [1:0]  w_state_next;
  logic [2:0]  w_byte_cnt_next;
  logic [7:0]  w_poll_cnt_next;
  logic [5:0]  w_index_next;
  logic [31:0] w_arg_next;
  logic [6:0]  w_crc_next;
  logic [7:0]  w_out_next;
  logic        w_en_next;
  logic        w_busy_next;
  logic        w_done_next;
  logic [7:0]  w_resp_next;
  logic        w_timeout_next;

  logic        w_fall;
  logic [6:0]  w_crc_sel;

  // CRC7, generator x^7 + x^3 + 1, zero initial value, MSB first.
  function automatic logic [6:0] crc7_calc(input logic [39:0] data);
    logic [6:0] c;
    logic       fb;
    c = 7'd0;
    for (int i = 39; i >= 0; i--) begin
      fb = data[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) begin
        c = c ^ 7'h09;
      end
    end
    return c;
  endfunction

  // Frame byte selected by position: start/index, 4 argument bytes, CRC/stop.
  function automatic logic [7:0] frame_byte(
    input logic [2:0]  sel,
    input logic [5:0]  idx,
    input logic [31:0] arg,
    input logic [6:0]  crc
  );
    logic [7:0] b;
    case (sel)
      3'd0:    b = {2'b01, idx};
      3'd1:    b = arg[31:24];
      3'd2:    b = arg[23:16];
      3'd3:    b = arg[15:8];
      3'd4:    b = arg[7:0];
      3'd5:    b = {crc, 1'b1};
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

`ifdef SD_CMD_CRC_GEN_EN
  // CRC is derived from the live inputs so it is ready at the accept edge.
  logic w_unused_cmd_crc;
  assign w_unused_cmd_crc = ^cmd_crc;
  assign w_crc_sel = crc7_calc({2'b01, cmd_index, cmd_arg});
`else
  assign w_crc_sel = cmd_crc;
`endif

  // A byte completes when the strobe was high last cycle and is low now.
  assign w_fall = r_dclk_prev & ~DataClockRegister;

  // Next-state and next-output decode for the sequencer.
  always_comb begin
    w_state_next    = r_state;
    w_byte_cnt_next = r_byte_cnt;
    w_poll_cnt_next = r_poll_cnt;
    w_index_next    = r_index;
    w_arg_next      = r_arg;
    w_crc_next      = r_crc;
    w_out_next      = 8'hFF;
    w_en_next       = 1'b0;
    w_busy_next     = 1'b0;
    w_done_next     = 1'b0;
    w_resp_next     = r_resp;
    w_timeout_next  = r_timeout;

    case (r_state)
      IDLE: begin
        w_byte_cnt_next = 3'd0;
        w_poll_cnt_next = 8'd0;
        if (cmd_start) begin
          w_index_next    = cmd_index;
          w_arg_next      = cmd_arg;
          w_crc_next      = w_crc_sel;
          w_timeout_next  = 1'b0;
          w_state_next    = SEND;
          w_busy_next     = 1'b1;
          w_en_next       = 1'b1;
          w_out_next      = {2'b01, cmd_index};
        end
      end

      SEND: begin
        w_busy_next = 1'b1;
        w_en_next   = 1'b1;
        w_out_next  = frame_byte(r_byte_cnt, r_index, r_arg, r_crc);
        // Whatever the engine shifts in while the frame goes out is dropped.
        if (w_fall) begin
          if (r_byte_cnt == LAST_BYTE) begin
            w_state_next    = POLL;
            w_poll_cnt_next = 8'd0;
            w_out_next      = 8'hFF;
          end else begin
            w_byte_cnt_next = r_byte_cnt + 3'd1;
            w_out_next      = frame_byte(r_byte_cnt + 3'd1, r_index, r_arg, r_crc);
          end
        end
      end

      POLL: begin
        w_busy_next = 1'b1;
        w_en_next   = 1'b1;
        if (w_fall) begin
          if (!InputDataRegister[7]) begin
            w_resp_next  = InputDataRegister;
            w_state_next = FINISH;
            w_busy_next  = 1'b0;
            w_en_next    = 1'b0;
            w_done_next  = 1'b1;
          end else if (r_poll_cnt == POLL_LAST) begin
            w_resp_next    = 8'hFF;
            w_timeout_next = 1'b1;
            w_state_next   = FINISH;
            w_busy_next    = 1'b0;
            w_en_next      = 1'b0;
            w_done_next    = 1'b1;
          end else begin
            w_poll_cnt_next = r_poll_cnt + 8'd1;
          end
        end
      end

      FINISH: begin
        // done is high for exactly this one cycle; strobes here are ignored.
        w_state_next    = IDLE;
        w_byte_cnt_next = 3'd0;
        w_poll_cnt_next = 8'd0;
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Strobe history register for falling-edge detection.
  always_ff @(posedge MasterCLK or negedge Reset) begin
    if (!Reset) begin
      r_dclk_prev <= 1'b0;
    end else begin
      r_dclk_prev <= DataClockRegister;
    end
  end

  // Sequencer state, counters and latched command fields.
  always_ff @(posedge MasterCLK or negedge Reset) begin
    if (!Reset) begin
      r_state    <= IDLE;
      r_byte_cnt <= 3'd0;
      r_poll_cnt <= 8'd0;
      r_index    <= 6'd0;
      r_arg      <= 32'd0;
      r_crc      <= 7'd0;
    end else begin
      r_state    <= w_state_next;
      r_byte_cnt <= w_byte_cnt_next;
      r_poll_cnt <= w_poll_cnt_next;
      r_index    <= w_index_next;
      r_arg      <= w_arg_next;
      r_crc      <= w_crc_next;
    end
  end

  // Registered outputs, so every output changes only on a clock edge.
  always_ff @(posedge MasterCLK or negedge Reset) begin
    if (!Reset) begin
      r_out     <= 8'hFF;
      r_en      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_resp    <= 8'h00;
      r_timeout <= 1'b0;
    end else begin
      r_out     <= w_out_next;
      r_en      <= w_en_next;
      r_busy    <= w_busy_next;
      r_done    <= w_done_next;
      r_resp    <= w_resp_next;
      r_timeout <= w_timeout_next;
    end
  end

  assign OuputDataRegister  = r_out;
  assign SPI_EnableRegister = r_en;
  assign busy               = r_busy;
  assign done               = r_done;
  assign resp               = r_resp;
  assign timeout            = r_timeout;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// tb_sd_cmd_sequencer: directed and randomized checks of sd_cmd_sequencer
// against a byte-level model of the SD command frame and R1 polling.
module tb_sd_cmd_sequencer;

  localparam int POLL_LIMIT = 8;

  logic        MasterCLK = 1'b0;
  logic        Reset = 1'b0;
  logic        cmd_start = 1'b0;
  logic [5:0]  cmd_index = '0;
  logic [31:0] cmd_arg = '0;
  logic [6:0]  cmd_crc = '0;
  logic        busy;
  logic        done;
  logic [7:0]  resp;
  logic        timeout;
  logic [7:0]  OuputDataRegister;
  logic        SPI_EnableRegister;
  logic [7:0]  InputDataRegister = 8'hFF;
  logic        DataClockRegister = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;

  sd_cmd_sequencer #(.POLL_LIMIT(POLL_LIMIT)) dut (
    .MasterCLK          (MasterCLK),
    .Reset              (Reset),
    .cmd_start          (cmd_start),
    .cmd_index          (cmd_index),
    .cmd_arg            (cmd_arg),
    .cmd_crc            (cmd_crc),
    .busy               (busy),
    .done               (done),
    .resp               (resp),
    .timeout            (timeout),
    .OuputDataRegister  (OuputDataRegister),
    .SPI_EnableRegister (SPI_EnableRegister),
    .InputDataRegister  (InputDataRegister),
    .DataClockRegister  (DataClockRegister)
  );

  always #5 MasterCLK = ~MasterCLK;

  // Count every clock on which done is seen high.
  always @(posedge MasterCLK) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference CRC7 as polynomial remainder of message * x^7 mod 0x89.
  function automatic logic [6:0] ref_crc7(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'd0};
    for (int i = 46; i >= 7; i--) begin
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    end
    return r[6:0];
  endfunction

  // Expected byte b (0..5) of the command frame.
  function automatic logic [7:0] exp_frame(input int b, input logic [5:0] idx,
                                           input logic [31:0] arg, input logic [6:0] crc);
    logic [47:0] f;
    logic [6:0]  c;
    c = crc;
`ifdef SD_CMD_CRC_GEN_EN
    c = ref_crc7({2'b01, idx, arg});
`endif
    f = {8'h40 | {2'b00, idx}, arg, c, 1'b1};
    return f[47 - 8*b -: 8];
  endfunction

  // One engine byte: strobe high 1..3 cycles, then low; returns at the
  // negedge after the DUT has seen the falling edge.
  task automatic do_byte(input logic [7:0] v);
    InputDataRegister = v;
    DataClockRegister = 1'b1;
    repeat ($urandom_range(1, 3)) @(negedge MasterCLK);
    DataClockRegister = 1'b0;
    @(negedge MasterCLK);
  endtask

  // Full command: frame, polls, completion. valid_at is the poll number that
  // carries the R1 byte; anything >= POLL_LIMIT means no answer.
  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc,
                         input int valid_at, input logic [7:0] rval, input bit inject);
    int         d0;
    int         polls;
    logic [7:0] exp_resp;
    logic       exp_to;
    logic [7:0] v;
    d0 = done_cnt;
    @(negedge MasterCLK);
    cmd_start = 1'b1;
    cmd_index = idx;
    cmd_arg   = arg;
    cmd_crc   = crc;
    @(negedge MasterCLK);
    cmd_start = 1'b0;
    check("busy_accept", busy, 1);
    check("en_accept", SPI_EnableRegister, 1);
    check("timeout_clear", timeout, 0);
    for (int b = 0; b < 6; b++) begin
      if (inject && b == 2) begin
        cmd_start = 1'b1;
        cmd_index = ~idx;
        cmd_arg   = ~arg;
        cmd_crc   = ~crc;
        @(negedge MasterCLK);
        cmd_start = 1'b0;
      end
      check($sformatf("frame_b%0d", b), OuputDataRegister, exp_frame(b, idx, arg, crc));
      check("busy_send", busy, 1);
      do_byte(8'($urandom));
    end
    polls    = 0;
    exp_resp = 8'hFF;
    exp_to   = 1'b1;
    for (int p = 0; p < POLL_LIMIT; p++) begin
      check("poll_byte", OuputDataRegister, 8'hFF);
      check("en_poll", SPI_EnableRegister, 1);
      if (p == valid_at) v = rval & 8'h7F;
      else v = 8'($urandom) | 8'h80;
      do_byte(v);
      polls++;
      if (p == valid_at) begin
        exp_resp = v;
        exp_to   = 1'b0;
        break;
      end
    end
    check("done_pulse", done, 1);
    check("busy_finish", busy, 0);
    check("en_finish", SPI_EnableRegister, 0);
    check("out_finish", OuputDataRegister, 8'hFF);
    check("resp", resp, exp_resp);
    check("timeout", timeout, exp_to);
    @(negedge MasterCLK);
    check("done_low", done, 0);
    check("done_count", done_cnt - d0, 1);
    $display("cmd idx=%0d arg=%08h polls=%0d resp=%02h timeout=%0d", idx, arg, polls, resp, timeout);
  endtask

  initial begin
    int d0;
    int va;
    // Reset state
    repeat (3) @(negedge MasterCLK);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_resp", resp, 8'h00);
    check("rst_timeout", timeout, 0);
    check("rst_en", SPI_EnableRegister, 0);
    check("rst_out", OuputDataRegister, 8'hFF);
    Reset = 1'b1;
    @(negedge MasterCLK);

    // CMD0: R1 0x01 on the second poll
    run_cmd(6'd0, 32'h0, 7'h4A, 1, 8'h01, 1'b0);
    // CMD8: byte 6 is 0x87 whether generated or supplied
    run_cmd(6'd8, 32'h000001AA, 7'h43, 0, 8'h01, 1'b0);
    // No answer: exactly POLL_LIMIT polls then timeout
    run_cmd(6'd55, $urandom, 7'($urandom), POLL_LIMIT, 8'h00, 1'b0);
    // cmd_start during SEND is ignored
    run_cmd(6'd17, $urandom, 7'($urandom), 3, 8'($urandom), 1'b1);

    // Strobes while idle change nothing
    d0 = done_cnt;
    repeat (4) do_byte(8'($urandom));
    check("idle_en", SPI_EnableRegister, 0);
    check("idle_busy", busy, 0);
    check("idle_out", OuputDataRegister, 8'hFF);
    check("idle_done_count", done_cnt - d0, 0);

    // Timeout first so resp is non-zero, then reset after the 3rd byte
    run_cmd(6'd1, $urandom, 7'($urandom), POLL_LIMIT, 8'h00, 1'b0);
    @(negedge MasterCLK);
    cmd_start = 1'b1;
    cmd_index = 6'd24;
    cmd_arg   = $urandom;
    @(negedge MasterCLK);
    cmd_start = 1'b0;
    repeat (3) do_byte(8'h00);
    d0 = done_cnt;
    #2 Reset = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_resp", resp, 8'h00);
    check("mid_rst_timeout", timeout, 0);
    check("mid_rst_en", SPI_EnableRegister, 0);
    check("mid_rst_out", OuputDataRegister, 8'hFF);
    repeat (3) @(negedge MasterCLK);
    Reset = 1'b1;
    @(negedge MasterCLK);
    check("mid_rst_no_done", done_cnt - d0, 0);
    run_cmd(6'd24, $urandom, 7'($urandom), 0, 8'h00, 1'b0);

    // Randomized commands
    for (int n = 0; n < 12; n++) begin
      va = $urandom_range(0, POLL_LIMIT);
      run_cmd(6'($urandom), $urandom, 7'($urandom), va, 8'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
